// File: rtl/clint_slave_if.sv
// rtl/clint_slave_if.sv - data-memory bus seen by the CLINT responder
// Carries the MEM-stage access fields and the combinational load data.
interface clint_slave_if;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [31:0] mem_addr_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;

   modport slave (
      input  mem_ce_i,
      input  mem_we_i,
      input  mem_addr_i,
      input  mem_sel_i,
      input  mem_data_i,
      output mem_data_o
   );

   modport master (
      output mem_ce_i,
      output mem_we_i,
      output mem_addr_i,
      output mem_sel_i,
      output mem_data_i,
      input  mem_data_o
   );
endinterface

// File: rtl/clint_slave.sv
// rtl/clint_slave.sv - core-local interruptor: MSIP, MTIME, MTIMECMP responder
// Bus reads are combinational and zero when not addressed so responders can be OR-muxed.
module clint_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic                clk,
   input  logic                rst,
   clint_slave_if.slave        bus,
   input  logic [31:0]         csr_mie_i,
   input  logic [31:0]         csr_mstatus_i,
   output logic                interrupt_clint,
   output logic [30:0]         exception_code_clint,
   output logic [63:0]         mtime_o
);

   localparam logic [13:0] OFF_MSIP      = 14'h0000;
   localparam logic [13:0] OFF_MTIMECMP0 = 14'h1000;
   localparam logic [13:0] OFF_MTIMECMP1 = 14'h1001;
   localparam logic [13:0] OFF_MTIME0    = 14'h2FFE;
   localparam logic [13:0] OFF_MTIME1    = 14'h2FFF;
   localparam logic [15:0] PRESC_MAX     = 16'(TICK_DIV - 1);

   logic        msip_q, msip_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [15:0] presc_q, presc_d;
   logic        mtip_q, mtip_d;

   logic        hit;
   logic        wr_en;
   logic [13:0] word_off;
   logic        tick;
   logic        sw_pend;
   logic        tm_pend;
   logic        unused_bits;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end
      end
      return res;
   endfunction

   assign hit      = bus.mem_ce_i && (bus.mem_addr_i[31:16] == BASE_ADDR[31:16]);
   assign wr_en    = hit && bus.mem_we_i;
   assign word_off = bus.mem_addr_i[15:2];
   assign tick     = (presc_q == PRESC_MAX);

   assign unused_bits = ^{bus.mem_addr_i[1:0], csr_mie_i[31:8], csr_mie_i[6:4],
                          csr_mie_i[2:0], csr_mstatus_i[31:4], csr_mstatus_i[2:0]};

   always_comb begin
      bus.mem_data_o = 32'h0;
      if (hit && !bus.mem_we_i) begin
         case (word_off)
            OFF_MSIP:      bus.mem_data_o = {31'h0, msip_q};
            OFF_MTIMECMP0: bus.mem_data_o = mtimecmp_q[31:0];
            OFF_MTIMECMP1: bus.mem_data_o = mtimecmp_q[63:32];
            OFF_MTIME0:    bus.mem_data_o = mtime_q[31:0];
            OFF_MTIME1:    bus.mem_data_o = mtime_q[63:32];
            default:       bus.mem_data_o = 32'h0;
         endcase
      end
   end

   // A software write to either MTIME half swallows that cycle's tick entirely.
   always_comb begin
      msip_d     = msip_q;
      mtimecmp_d = mtimecmp_q;
      mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
      presc_d    = tick ? 16'd0 : (presc_q + 16'd1);
      mtip_d     = (mtime_q >= mtimecmp_q);

      if (wr_en) begin
         case (word_off)
            OFF_MSIP: begin
               if (bus.mem_sel_i[0]) begin
                  msip_d = bus.mem_data_i[0];
               end
            end
            OFF_MTIMECMP0: begin
               mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], bus.mem_data_i, bus.mem_sel_i);
            end
            OFF_MTIMECMP1: begin
               mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus.mem_data_i, bus.mem_sel_i);
            end
            OFF_MTIME0: begin
               mtime_d = {mtime_q[63:32],
                          merge_bytes(mtime_q[31:0], bus.mem_data_i, bus.mem_sel_i)};
            end
            OFF_MTIME1: begin
               mtime_d = {merge_bytes(mtime_q[63:32], bus.mem_data_i, bus.mem_sel_i),
                          mtime_q[31:0]};
            end
            default: begin
               msip_d = msip_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         msip_q     <= 1'b0;
         mtime_q    <= 64'h0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         presc_q    <= 16'h0;
         mtip_q     <= 1'b0;
      end else begin
         msip_q     <= msip_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         presc_q    <= presc_d;
         mtip_q     <= mtip_d;
      end
   end

   // Software interrupt outranks the timer when both are enabled and pending.
   assign sw_pend = msip_q && csr_mie_i[3];
   assign tm_pend = mtip_q && csr_mie_i[7];

   assign interrupt_clint      = csr_mstatus_i[3] && (sw_pend || tm_pend);
   assign exception_code_clint = sw_pend ? 31'd3 : (tm_pend ? 31'd7 : 31'd0);
   assign mtime_o              = mtime_q;

endmodule
